// File: rtl/vecunit_pkg.sv
// vecunit_pkg: shared types for the vector FP add sequencer
package vecunit_pkg;
  localparam int FP32_W = 32;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} seq_state_e;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;
endpackage

// File: rtl/vseq_delay_line.sv
// vseq_delay_line: fixed-depth {valid, data} shift register with synchronous flush
module vseq_delay_line #(
  parameter int DEPTH = 3,
  parameter int W     = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic [DEPTH-1:0] r_v;
  logic [W-1:0]     r_d [DEPTH];
  // shift one stage per cycle; flush drops every in-flight valid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
    end else begin
      r_v[0] <= valid_i && !flush_i;
      r_d[0] <= data_i;
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k] <= r_v[k-1] && !flush_i;
        r_d[k] <= r_d[k-1];
      end
    end
  end
  assign valid_o = r_v[DEPTH-1];
  assign data_o  = r_d[DEPTH-1];
endmodule

// File: rtl/vfadd_elem_sequencer.sv
// vfadd_elem_sequencer: runs one vector FP add/sub element-by-element through a fixed-latency adder
module vfadd_elem_sequencer
  import vecunit_pkg::*;
#(
  parameter int VLMAX   = 32,
  parameter int ELEM_W  = FP32_W,
  parameter int ADD_LAT = 3,
  parameter int IDX_W   = $clog2(VLMAX)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_sub_i,
  input  logic [IDX_W:0]    cmd_vl_i,
  input  logic [4:0]        cmd_vs1_i,
  input  logic [4:0]        cmd_vs2_i,
  input  logic [4:0]        cmd_vd_i,
  input  logic              kill_i,
  output logic              rf_rd_en_o,
  output logic [4:0]        rf_rd_vs1_o,
  output logic [4:0]        rf_rd_vs2_o,
  output logic [IDX_W-1:0]  rf_rd_idx_o,
  input  logic [ELEM_W-1:0] rf_rd_a_i,
  input  logic [ELEM_W-1:0] rf_rd_b_i,
  output logic              add_valid_o,
  output logic [ELEM_W-1:0] add_a_o,
  output logic [ELEM_W-1:0] add_b_o,
  output logic              add_sub_o,
  input  logic              add_valid_i,
  input  logic [ELEM_W-1:0] add_result_i,
  input  logic [4:0]        add_flags_i,
  output logic              rf_wr_en_o,
  output logic [4:0]        rf_wr_vd_o,
  output logic [IDX_W-1:0]  rf_wr_idx_o,
  output logic [ELEM_W-1:0] rf_wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [4:0]        fflags_o,
  output logic              err_o
);
  seq_state_e       r_state, w_next;
  logic             r_sub, r_iss_v, r_err;
  logic [IDX_W:0]   r_vl;
  logic [4:0]       r_vs1, r_vs2, r_vd;
  logic [IDX_W-1:0] r_rd_idx, r_iss_idx, w_dl_idx;
  fflags_t          r_fflags;
  logic             w_kill, w_rd_en, w_last_rd, w_dl_v, w_wr_en, w_last_wb;
  logic [IDX_W:0]   w_vl_m1;

  assign w_vl_m1   = r_vl - {{IDX_W{1'b0}}, 1'b1};
  assign w_kill    = kill_i && r_state != S_IDLE;
  assign w_rd_en   = r_state == S_ISSUE && !w_kill;
  assign w_last_rd = {1'b0, r_rd_idx} == w_vl_m1;
  assign w_wr_en   = w_dl_v && !w_kill;
  assign w_last_wb = w_wr_en && {1'b0, w_dl_idx} == w_vl_m1;

  vseq_delay_line #(.DEPTH(ADD_LAT), .W(IDX_W)) u_dl (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (w_kill),
    .valid_i (add_valid_o),
    .data_i  (r_iss_idx),
    .valid_o (w_dl_v),
    .data_o  (w_dl_idx)
  );

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // next state and handshake outputs; kill from any active state returns to idle
  always_comb begin
    w_next      = r_state;
    cmd_ready_o = r_state == S_IDLE;
    busy_o      = r_state != S_IDLE;
    done_o      = r_state == S_DONE && !w_kill;
    unique case (r_state)
      S_IDLE:  if (cmd_valid_i) w_next = cmd_vl_i == '0 ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_last_rd) w_next = S_DRAIN;
      S_DRAIN: if (w_last_wb) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
    endcase
    if (w_kill) w_next = S_IDLE;
  end

  // command latch, read index, issue stage, flag accumulation and sticky tracking error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sub     <= 1'b0;
      r_vl      <= '0;
      r_vs1     <= '0;
      r_vs2     <= '0;
      r_vd      <= '0;
      r_rd_idx  <= '0;
      r_iss_v   <= 1'b0;
      r_iss_idx <= '0;
      r_fflags  <= '0;
      r_err     <= 1'b0;
    end else begin
      if (cmd_valid_i && r_state == S_IDLE) begin
        r_sub    <= cmd_sub_i;
        r_vl     <= cmd_vl_i;
        r_vs1    <= cmd_vs1_i;
        r_vs2    <= cmd_vs2_i;
        r_vd     <= cmd_vd_i;
        r_rd_idx <= '0;
        r_fflags <= '0;
      end else if (w_rd_en && !w_last_rd) begin
        r_rd_idx <= r_rd_idx + 1'b1;
      end
      r_iss_v   <= w_rd_en;
      r_iss_idx <= r_rd_idx;
      if (w_wr_en) r_fflags <= r_fflags | add_flags_i;
      if (add_valid_i != w_dl_v) r_err <= 1'b1;
    end
  end

  assign rf_rd_en_o   = w_rd_en;
  assign rf_rd_vs1_o  = r_vs1;
  assign rf_rd_vs2_o  = r_vs2;
  assign rf_rd_idx_o  = r_rd_idx;
  assign add_valid_o  = r_iss_v && !w_kill;
  assign add_a_o      = add_valid_o ? rf_rd_a_i : '0;
  assign add_b_o      = add_valid_o ? rf_rd_b_i : '0;
  assign add_sub_o    = r_sub;
  assign rf_wr_en_o   = w_wr_en;
  assign rf_wr_vd_o   = r_vd;
  assign rf_wr_idx_o  = w_wr_en ? w_dl_idx : '0;
  assign rf_wr_data_o = w_wr_en ? add_result_i : '0;
  assign fflags_o     = r_fflags;
  assign err_o        = r_err;
endmodule

// File: tb/tb_vfadd_elem_sequencer.sv
// tb_vfadd_elem_sequencer: directed self-checking bench with register-file and adder models
module tb_vfadd_elem_sequencer;
  localparam int IDX_W = 5;
  localparam int LAT   = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_sub = 1'b0, kill = 1'b0;
  logic [5:0]  cmd_vl = '0;
  logic        cmd_ready, rd_en, add_v, add_sub, wr_en, busy, done, err;
  logic [4:0]  rd_vs1, rd_vs2, wr_vd, fflags;
  logic [4:0]  rd_idx, wr_idx;
  logic [31:0] rd_a = '0, rd_b = '0, add_a, add_b, wr_data;
  logic        res_v;
  logic [31:0] res;
  logic [4:0]  res_f;
  logic [4:0]  flag_tab [32];
  logic        drop_en = 1'b0;
  logic [4:0]  drop_idx = '0;
  logic        pv [LAT];
  logic [31:0] pd [LAT];
  logic [4:0]  pi [LAT];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  vfadd_elem_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_sub_i(cmd_sub), .cmd_vl_i(cmd_vl), .cmd_vs1_i(5'd1), .cmd_vs2_i(5'd2), .cmd_vd_i(5'd3),
    .kill_i(kill), .rf_rd_en_o(rd_en), .rf_rd_vs1_o(rd_vs1), .rf_rd_vs2_o(rd_vs2),
    .rf_rd_idx_o(rd_idx), .rf_rd_a_i(rd_a), .rf_rd_b_i(rd_b), .add_valid_o(add_v),
    .add_a_o(add_a), .add_b_o(add_b), .add_sub_o(add_sub), .add_valid_i(res_v),
    .add_result_i(res), .add_flags_i(res_f), .rf_wr_en_o(wr_en), .rf_wr_vd_o(wr_vd),
    .rf_wr_idx_o(wr_idx), .rf_wr_data_o(wr_data), .busy_o(busy), .done_o(done),
    .fflags_o(fflags), .err_o(err)
  );

  // register file: element value encodes register number and index, one-cycle read latency
  always @(posedge clk)
    if (rd_en) begin
      rd_a <= {16'hA000 | {11'd0, rd_vs1}, 11'd0, rd_idx};
      rd_b <= {16'hB000 | {11'd0, rd_vs2}, 11'd0, rd_idx};
    end

  // fixed-latency adder, flushed by kill, with an optional dropped valid for one element
  always @(posedge clk or negedge rst_n)
    if (!rst_n || kill) begin
      for (int k = 0; k < LAT; k++) begin pv[k] <= 1'b0; pd[k] <= '0; pi[k] <= '0; end
    end else begin
      pv[0] <= add_v;
      pd[0] <= add_sub ? add_a - add_b : add_a + add_b;
      pi[0] <= add_a[4:0];
      for (int k = 1; k < LAT; k++) begin pv[k] <= pv[k-1]; pd[k] <= pd[k-1]; pi[k] <= pi[k-1]; end
    end
  assign res_v = pv[LAT-1] && !(drop_en && pi[LAT-1] == drop_idx);
  assign res   = pd[LAT-1];
  assign res_f = pv[LAT-1] ? flag_tab[pi[LAT-1]] : 5'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int vl, input logic sub, input logic [4:0] ff);
    int dc;
    dc = (vl == 0) ? 1 : vl + 5;
    cmd_valid = 1'b1; cmd_vl = 6'(vl); cmd_sub = sub;
    #1 chk("ready_c0", {31'd0, cmd_ready}, 1);
    for (int c = 1; c <= dc + 1; c++) begin
      tick();
      cmd_valid = 1'b0;
      #1;
      chk("rd_en", {31'd0, rd_en}, {31'd0, c <= vl});
      if (c <= vl) chk("rd_idx", {27'd0, rd_idx}, c - 1);
      chk("add_valid", {31'd0, add_v}, {31'd0, c >= 2 && c <= vl + 1});
      chk("wr_en", {31'd0, wr_en}, {31'd0, vl > 0 && c >= 5 && c <= vl + 4});
      if (vl > 0 && c >= 5 && c <= vl + 4) begin
        chk("wr_idx", {27'd0, wr_idx}, c - 5);
        chk("wr_vd", {27'd0, wr_vd}, 3);
        chk("wr_data", wr_data, sub ? 32'hEFFF_0000 : 32'h5003_0000 + 32'(2 * (c - 5)));
      end
      chk("done", {31'd0, done}, {31'd0, c == dc});
      if (c == dc) chk("fflags", {27'd0, fflags}, {27'd0, ff});
      chk("ready", {31'd0, cmd_ready}, {31'd0, c == dc + 1});
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) flag_tab[k] = '0;
    tick(); tick();
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_fflags", {27'd0, fflags}, 0);
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    rst_n = 1'b1;
    tick();
    run(4, 1'b0, 5'd0);
    run(0, 1'b0, 5'd0);
    flag_tab[2] = 5'b00001; flag_tab[3] = 5'b00100;
    run(4, 1'b1, 5'b00101);
    flag_tab[2] = '0; flag_tab[3] = '0;
    // kill mid-instruction
    cmd_valid = 1'b1; cmd_vl = 6'd8; cmd_sub = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      cmd_valid = 1'b0;
      kill = c == 4;
      #1;
      if (c == 4) begin
        chk("kill_wr_en", {31'd0, wr_en}, 0);
        chk("kill_rd_en", {31'd0, rd_en}, 0);
        chk("kill_add_v", {31'd0, add_v}, 0);
      end
      if (c == 5) chk("kill_ready", {31'd0, cmd_ready}, 1);
      if (c >= 5) chk("kill_no_wr", {31'd0, wr_en}, 0);
      chk("kill_no_done", {31'd0, done}, 0);
    end
    kill = 1'b0;
    chk("kill_fflags", {27'd0, fflags}, 0);
    chk("kill_err", {31'd0, err}, 0);
    // second command held while the first runs
    flag_tab[1] = 5'b10000;
    cmd_valid = 1'b1; cmd_vl = 6'd2; cmd_sub = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 1) begin cmd_vl = 6'd1; cmd_sub = 1'b1; end
      if (c == 9) cmd_valid = 1'b0;
      #1;
      chk("b2b_ready", {31'd0, cmd_ready}, {31'd0, c == 8 || c == 15});
      chk("b2b_done", {31'd0, done}, {31'd0, c == 7 || c == 14});
      if (c == 7) chk("b2b_ff1", {27'd0, fflags}, 5'b10000);
      if (c == 9) chk("b2b_rd2", {31'd0, rd_en}, 1);
      if (c == 13) chk("b2b_wr2", wr_data, 32'hEFFF_0000);
      if (c == 14) chk("b2b_ff2", {27'd0, fflags}, 0);
    end
    flag_tab[1] = '0;
    // adder drops element 1's valid
    drop_en = 1'b1; drop_idx = 5'd1;
    cmd_valid = 1'b1; cmd_vl = 6'd4; cmd_sub = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      cmd_valid = 1'b0;
      #1;
      chk("err", {31'd0, err}, {31'd0, c >= 7});
      if (c == 6) begin
        chk("err_wr_en", {31'd0, wr_en}, 1);
        chk("err_wr_idx", {27'd0, wr_idx}, 1);
      end
      if (c == 9) chk("err_done", {31'd0, done}, 1);
    end
    drop_en = 1'b0;
    // asynchronous reset mid-operation
    cmd_valid = 1'b1; cmd_vl = 6'd8;
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, cmd_ready}, 1);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_rd_en", {31'd0, rd_en}, 0);
    chk("arst_add_v", {31'd0, add_v}, 0);
    chk("arst_err", {31'd0, err}, 0);
    chk("arst_fflags", {27'd0, fflags}, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("post_rst_wr", {31'd0, wr_en}, 0);
      chk("post_rst_rd", {31'd0, rd_en}, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vfadd_elem_sequencer.md
Name: vfadd_elem_sequencer

Overview:
- Sequences one vector FP add/sub instruction element-by-element through the shared fixed-latency FP32 add pipeline in the vecunit.
- Issues register-file reads, feeds operand pairs to the adder, and tracks each element index through the adder latency.
- Writes results back to vd, accumulates exception flags, and signals completion.
- Sits between the CV-X-IF decode/issue stage and the vector register file / FP adder.

Parameters:
VLMAX, 32, maximum elements per vector register
ELEM_W, 32, element width (FP32)
ADD_LAT, 3, adder latency in cycles from add_valid_o to result (>=1)
IDX_W, $clog2(VLMAX), element index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  sequencer idle, command accepted when valid&ready
cmd_sub_i  in  1  1 = subtract (vs1 - vs2), 0 = add
cmd_vl_i  in  IDX_W+1  element count, 0..VLMAX
cmd_vs1_i / cmd_vs2_i / cmd_vd_i  in  5 each  register numbers
kill_i  in  1  abort current instruction
rf_rd_en_o  out  1  read strobe; data returns next cycle
rf_rd_vs1_o / rf_rd_vs2_o  out  5 each  read registers
rf_rd_idx_o  out  IDX_W  element index
rf_rd_a_i / rf_rd_b_i  in  ELEM_W each  read data (1-cycle latency)
add_valid_o  out  1  operands valid to adder
add_a_o / add_b_o  out  ELEM_W each  operands
add_sub_o  out  1  operation to adder
add_valid_i  in  1  adder result valid
add_result_i  in  ELEM_W  adder result
add_flags_i  in  5  NV,DZ,OF,UF,NX (bit4..0)
rf_wr_en_o  out  1  write strobe (always accepted)
rf_wr_vd_o  out  5  write register
rf_wr_idx_o  out  IDX_W  write element index
rf_wr_data_o  out  ELEM_W  write data
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
fflags_o  out  5  OR of all element flags; valid with done_o
err_o  out  1  sticky: add_valid_i disagrees with tracked delay line

Behaviour:
- Reset: all outputs 0 except cmd_ready_o = 1; state IDLE; counters, delay line and flags cleared.
- FSM states:
  - IDLE -> ISSUE on accept (vl != 0); IDLE -> DONE on accept with vl == 0.
  - ISSUE -> DRAIN after the read of element vl-1.
  - DRAIN -> DONE when the delay line is empty and the last writeback has occurred.
  - DONE -> IDLE unconditionally; done_o = 1 only in DONE.
- Accept (cycle 0): latch sub, vl, vs1, vs2, vd; clear fflags accumulator.
- Read: element i read at cycle 1+i, one per cycle, no bubbles.
- Adder issue: operands presented at cycle 2+i with add_valid_o = 1. The index travels through a registered stage, then an ADD_LAT-deep valid/index delay line.
- Writeback at cycle 2+i+ADD_LAT: rf_wr_en_o = delay-line valid, data = add_result_i, flags ORed into the accumulator.
- done_o at cycle 2+vl+ADD_LAT; vl = 0 gives done_o at cycle 1 with no rf or adder activity.
- err_o: set when add_valid_i != delay-line valid output; cleared only by reset. Writeback follows the delay line regardless.
- cmd_ready_o = (state == IDLE). Commands arriving while busy are held by the requester.
- kill_i (any non-IDLE state): reads, adder issue and writebacks stop in the same cycle. Delay line flushed; next state IDLE; no done_o; fflags_o not updated.
- kill_i in IDLE is ignored.
- Counters: read index saturates at vl-1. Index width IDX_W; vl = VLMAX handled without wrap by the IDX_W+1 count.
- Asynchronous reset mid-operation: immediate return to reset values; no partial writes after deassertion.

Decomposition:
- vecunit_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), fflag bit positions, FP32 width constant.
- Sub-module vseq_delay_line: parameterized depth/width shift register of {valid, idx} with synchronous flush.

Test Plan:
- vl=4, ADD_LAT=3, add: accept cycle 0 -> reads cycles 1-4; rf_wr idx 0..3 at cycles 5..8 with adder results; done_o cycle 9; cmd_ready_o back at cycle 10.
- vl=0 -> done_o cycle 1; rf_rd_en_o, add_valid_o and rf_wr_en_o never asserted.
- vl=4; element 2 returns flags 5'b00001, element 3 returns 5'b00100 -> fflags_o = 5'b00101 at done_o.
- vl=8; kill_i at cycle 4 -> no rf_wr_en_o from cycle 4 on; cmd_ready_o = 1 at cycle 5; done_o never pulses.
- Second command held valid during the first (vl=2) -> accepted in the cycle after done_o; first command's fflags do not leak into the second.
- Adder model drops add_valid_i for element 1 -> err_o = 1 from that cycle until reset. Separately, reset asserted at cycle 3 -> all outputs at reset values immediately.
